// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {pc, instr, adel} between fetch and decode.
// Optional same-cycle bypass of an empty buffer is enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_adel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [31:0]      pc_mem_r    [DEPTH];
  logic [31:0]      instr_mem_r [DEPTH];
  logic [DEPTH-1:0] adel_mem_r;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_valid_s;
  logic byp_s;

  // Pointer MSB acts as the wrap bit so full and empty stay distinguishable.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign head_valid_s = !empty_s && !flush;
  assign in_ready = !full_s && !flush;
  assign count    = wr_ptr_r - rd_ptr_r;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp_s  = empty_s && in_valid && !flush;
  // A bypassed entry that the decoder takes immediately never touches storage.
  assign push_s = in_valid && in_ready && !(byp_s && out_ready);
  assign pop_s  = head_valid_s && out_ready;
`else
  assign byp_s  = 1'b0;
  assign push_s = in_valid && in_ready;
  assign pop_s  = head_valid_s && out_ready;
`endif

  // Decoder-facing outputs: NOP fields whenever nothing valid is presented.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0000_0000;
    out_instr = 32'h0000_0000;
    out_adel  = 1'b0;
    if (byp_s) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
      out_adel  = in_adel;
    end else if (head_valid_s) begin
      out_valid = 1'b1;
      out_pc    = pc_mem_r[rd_ptr_r[AW-1:0]];
      out_instr = instr_mem_r[rd_ptr_r[AW-1:0]];
      out_adel  = adel_mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      out_valid = 1'b0;
    end
  end

  // Read/write pointer update; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; contents are left as-is on reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      pc_mem_r[wr_ptr_r[AW-1:0]]    <= in_pc;
      instr_mem_r[wr_ptr_r[AW-1:0]] <= in_instr;
      adel_mem_r[wr_ptr_r[AW-1:0]]  <= in_adel;
    end
  end

endmodule
